// File: rtl/clk_gate_pkg.sv
// Shared state encoding and default timing constants for the clock-gate run-enable controller.
// Purely declarative: no latency, no flow control.
// Consumers import clk_gate_pkg::* to agree on the state encoding seen on state_o.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  localparam int unsigned DEF_DRAIN_CYCLES = 4;
  localparam int unsigned DEF_WAKE_CYCLES  = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_gate_dly_cnt.sv
// Loadable down-counter; zero flags an expired delay, combinationally from the count register.
// Load takes effect on the next edge; decrement stops at zero so the count never wraps.
// No backpressure: load has priority over en.
module clk_gate_dly_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Run-enable controller for a downstream AND-style clock gate (RUN/DRAIN/GATED/WAKE).
// Latency: gating DRAIN_CYCLES edges after an accepted sleep, wake_done WAKE_CYCLES after wake.
// busy blocks or aborts sleep; optional idle auto-sleep under CLK_GATE_AUTO_SLEEP_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned WAKE_CYCLES  = DEF_WAKE_CYCLES,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       busy,
  output logic       run_en,
  output logic       sleep_ack,
  output logic       wake_done,
  output logic [1:0] state_o
);

  if (DRAIN_CYCLES == 0 || WAKE_CYCLES == 0 ||
      (max3(DRAIN_CYCLES, WAKE_CYCLES, IDLE_TIMEOUT) >> CNT_W) != 0) begin : g_bad_param
    $error("clk_gate_ctrl: cycle counts must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;
  logic             sleep_go;
  logic             auto_sleep;
  logic             run_en_d;
  logic             sleep_ack_d;
  logic             wake_done_d;

  clk_gate_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

`ifdef CLK_GATE_AUTO_SLEEP_EN
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_TIMEOUT);

  logic [CNT_W-1:0] idle_cnt;
  logic             idle_hit;

  assign idle_hit = (idle_cnt == IDLE_LIM);
  assign sleep_go = sleep_req || idle_hit;

  // auto_sleep remembers that this drain was idle-initiated, so dropping sleep_req must not abort it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt   <= '0;
      auto_sleep <= 1'b0;
    end else begin
      if (state != ST_RUN || state_nxt != ST_RUN || busy) begin
        idle_cnt <= '0;
      end else if (!sleep_req && !idle_hit) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
      if (state == ST_RUN && state_nxt == ST_DRAIN) begin
        auto_sleep <= idle_hit;
      end else if (state_nxt != ST_DRAIN) begin
        auto_sleep <= 1'b0;
      end
    end
  end
`else
  assign sleep_go   = sleep_req;
  assign auto_sleep = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      run_en    <= 1'b1;
      sleep_ack <= 1'b0;
      wake_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_en    <= run_en_d;
      sleep_ack <= sleep_ack_d;
      wake_done <= wake_done_d;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    case (state)
      ST_RUN: begin
        if (sleep_go && !busy) begin
          state_nxt    = ST_DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (busy || (!sleep_req && !auto_sleep)) begin
          state_nxt = ST_RUN;
        end else if (cnt_zero) begin
          state_nxt = ST_GATED;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_GATED: begin
        if (wake_req) begin
          state_nxt    = ST_WAKE;
          cnt_load     = 1'b1;
          cnt_load_val = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_zero) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs are derived from the next state so they flip on the same edge that changes state.
  always_comb begin
    run_en_d    = (state_nxt != ST_GATED);
    sleep_ack_d = (state_nxt == ST_GATED);
    wake_done_d = (state == ST_WAKE) && (state_nxt == ST_RUN);
  end

  assign state_o = state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: expectations are queued as each step is driven and checked after the edge.
// The idle auto-sleep section is only built with CLK_GATE_AUTO_SLEEP_EN.
module tb_clk_gate_ctrl;
  import clk_gate_pkg::*;

  logic       clk;
  logic       rst;
  logic       sleep_req;
  logic       wake_req;
  logic       busy;
  logic       run_en;
  logic       sleep_ack;
  logic       wake_done;
  logic [1:0] state_o;

  typedef struct packed {
    logic [1:0] st;
    logic       run;
    logic       ack;
    logic       wd;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  clk_gate_ctrl #(
    .DRAIN_CYCLES (4),
    .WAKE_CYCLES  (2),
    .CNT_W        (8),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sleep_req (sleep_req),
    .wake_req  (wake_req),
    .busy      (busy),
    .run_en    (run_en),
    .sleep_ack (sleep_ack),
    .wake_done (wake_done),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string fld, input logic [1:0] got,
                     input logic [1:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, fld, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic run,
                            input logic ack, input logic wd);
    exp_t e;
    e.st  = st;
    e.run = run;
    e.ack = ack;
    e.wd  = wd;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string tag;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      cmp(tag, "state_o",   state_o,   e.st);
      cmp(tag, "run_en",    run_en,    e.run);
      cmp(tag, "sleep_ack", sleep_ack, e.ack);
      cmp(tag, "wake_done", wake_done, e.wd);
    end
  endtask

  // Drive inputs, queue the expected outputs after the next edge, then sample 1 time unit past it.
  task automatic step(input logic s, input logic w, input logic b, input logic [1:0] st,
                      input logic run, input logic ack, input logic wd, input string tag);
    sleep_req = s;
    wake_req  = w;
    busy      = b;
    expect_out(tag, st, run, ack, wd);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic go_gated(input string tag);
    step(1, 0, 0, ST_DRAIN, 1, 0, 0, {tag, "_e"});
    for (int i = 1; i < 4; i++) step(1, 0, 0, ST_DRAIN, 1, 0, 0, {tag, "_drain"});
    step(1, 0, 0, ST_GATED, 0, 1, 0, {tag, "_gated"});
  endtask

  initial begin
    rst       = 1'b1;
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    busy      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("in_reset", ST_RUN, 1, 0, 0);
    check_out();
    rst = 1'b0;
    step(0, 0, 1, ST_RUN, 1, 0, 0, "after_reset");

    // Basic sleep: DRAIN at E, gated at E+4.
    go_gated("sleep");
    step(0, 0, 1, ST_GATED, 0, 1, 0, "gated_ignore_busy");
    step(0, 0, 0, ST_GATED, 0, 1, 0, "gated_ignore_drop");

    // Wake: run_en at W, wake_done only in the cycle after W+2.
    step(0, 1, 0, ST_WAKE, 1, 0, 0, "wake_entry");
    step(0, 0, 1, ST_WAKE, 1, 0, 0, "wake_settle");
    step(0, 0, 1, ST_RUN,  1, 0, 1, "wake_done");
    step(0, 0, 1, ST_RUN,  1, 0, 0, "wake_done_end");

    // Drain aborted by busy, then by sleep_req dropping.
    step(1, 0, 0, ST_DRAIN, 1, 0, 0, "abort_busy_e");
    step(1, 0, 0, ST_DRAIN, 1, 0, 0, "abort_busy_d");
    step(1, 0, 1, ST_RUN,   1, 0, 0, "abort_busy");
    step(1, 0, 1, ST_RUN,   1, 0, 0, "busy_blocks");
    step(1, 0, 0, ST_DRAIN, 1, 0, 0, "abort_drop_e");
    step(0, 0, 0, ST_RUN,   1, 0, 0, "abort_drop");
    step(0, 1, 1, ST_RUN,   1, 0, 0, "run_ignore_wake");

    // Sleep and wake together in GATED: wake wins, sleep held off until RUN.
    go_gated("simul");
    step(1, 1, 0, ST_WAKE,  1, 0, 0, "simul_wake");
    step(1, 0, 0, ST_WAKE,  1, 0, 0, "simul_hold");
    step(1, 0, 0, ST_RUN,   1, 0, 1, "simul_run");
    step(1, 0, 0, ST_DRAIN, 1, 0, 0, "simul_resleep");
    step(0, 0, 1, ST_RUN,   1, 0, 0, "simul_abort");

    // Async reset from GATED, observed before the next clock edge.
    go_gated("arst");
    #2;
    rst = 1'b1;
    #1;
    expect_out("arst_immediate", ST_RUN, 1, 0, 0);
    check_out();
    rst  = 1'b0;
    busy = 1'b1;
    step(0, 0, 1, ST_RUN, 1, 0, 0, "arst_after");

`ifdef CLK_GATE_AUTO_SLEEP_EN
    for (int i = 0; i < 16; i++) step(0, 0, 0, ST_RUN, 1, 0, 0, "idle_count");
    step(0, 0, 0, ST_DRAIN, 1, 0, 0, "auto_drain");
    for (int i = 1; i < 4; i++) step(0, 0, 0, ST_DRAIN, 1, 0, 0, "auto_hold");
    step(0, 0, 0, ST_GATED, 0, 1, 0, "auto_gated");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
